// File: rtl/ping_pong_sched.sv
// rtl/ping_pong_sched.sv - round-robin scheduler sharing one ping-pong counter between two requesters
// The owner's bounds are captured at grant; the counter runs for turn_tgt boundary turns.
module ping_pong_sched #(
  parameter int TURN_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [3:0]        max_a,
  input  logic [3:0]        min_a,
  input  logic [TURN_W-1:0] turns_a,
  input  logic [3:0]        max_b,
  input  logic [3:0]        min_b,
  input  logic [TURN_W-1:0] turns_b,
  input  logic [1:0]        flip_req,
  input  logic [3:0]        cnt_out,
  input  logic              cnt_dir,
  output logic              cnt_rst_n,
  output logic              cnt_en,
  output logic              cnt_flip,
  output logic [3:0]        cnt_max,
  output logic [3:0]        cnt_min,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic [1:0]        err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [3:0]        cnt_max_q, cnt_max_d;
  logic [3:0]        cnt_min_q, cnt_min_d;
  logic [TURN_W-1:0] turn_tgt_q, turn_tgt_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic              first_q, first_d;
  logic              ptr_q, ptr_d;

  logic              owner;
  logic              pick;
  logic [3:0]        pick_max;
  logic [3:0]        pick_min;
  logic [TURN_W-1:0] pick_turns;
  logic [TURN_W:0]   turn_nxt;
  logic              turn_evt;
  logic              last;
  logic              unused_dir;

  // Direction is not needed: turns are detected from the boundary values alone.
  assign unused_dir = cnt_dir;

  assign owner      = grant_q[1];
  assign pick       = req[ptr_q] ? ptr_q : ~ptr_q;
  assign pick_max   = pick ? max_b : max_a;
  assign pick_min   = pick ? min_b : min_a;
  assign pick_turns = pick ? turns_b : turns_a;

  assign turn_nxt = {1'b0, turn_cnt_q} + {{TURN_W{1'b0}}, 1'b1};
  assign turn_evt = ((cnt_out == cnt_max_q) || (cnt_out == cnt_min_q)) && !first_q;
  assign last     = turn_evt && (turn_nxt == {1'b0, turn_tgt_q});

  assign cnt_rst_n = rst_n && (state_q != LOAD);
  assign cnt_max   = cnt_max_q;
  assign cnt_min   = cnt_min_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = 2'b00;
    err_d      = 2'b00;
    cnt_max_d  = cnt_max_q;
    cnt_min_d  = cnt_min_q;
    turn_tgt_d = turn_tgt_q;
    turn_cnt_d = turn_cnt_q;
    first_d    = first_q;
    ptr_d      = ptr_q;
    cnt_en     = 1'b0;
    cnt_flip   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          if (pick_min < pick_max) begin
            cnt_max_d  = pick_max;
            cnt_min_d  = pick_min;
            turn_tgt_d = pick_turns;
            grant_d    = pick ? 2'b10 : 2'b01;
            state_d    = LOAD;
          end else begin
            err_d = pick ? 2'b10 : 2'b01;
            ptr_d = ~pick;
          end
        end
      end
      LOAD: begin
        turn_cnt_d = '0;
        first_d    = 1'b1;
        if (!req[owner]) begin
          state_d = IDLE;
          grant_d = 2'b00;
          ptr_d   = ~owner;
        end else if (turn_tgt_q == '0) begin
          state_d = DONE;
          done_d  = grant_q;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req[owner]) begin
          state_d = IDLE;
          grant_d = 2'b00;
          ptr_d   = ~owner;
        end else begin
          // Hold the enable low on the final turn so the counter parks on the boundary.
          cnt_en   = !last;
          cnt_flip = flip_req[owner] && !last;
          first_d  = 1'b0;
          if (turn_evt) begin
            turn_cnt_d = turn_nxt[TURN_W-1:0];
          end
          if (last) begin
            state_d = DONE;
            done_d  = grant_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
        ptr_d   = ~owner;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      cnt_max_q  <= 4'd0;
      cnt_min_q  <= 4'd0;
      turn_tgt_q <= '0;
      turn_cnt_q <= '0;
      first_q    <= 1'b0;
      ptr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cnt_max_q  <= cnt_max_d;
      cnt_min_q  <= cnt_min_d;
      turn_tgt_q <= turn_tgt_d;
      turn_cnt_q <= turn_cnt_d;
      first_q    <= first_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_ping_pong_sched.sv
// tb/tb_ping_pong_sched.sv - directed and randomized checks of ping_pong_sched with a behavioural counter
// Random transactions are predicted from bounds/turns arithmetic and round-robin order.
module tb_ping_pong_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [3:0] max_a, min_a, max_b, min_b;
  logic [3:0] turns_a, turns_b;
  logic [1:0] flip_req;
  logic [3:0] cnt_out;
  logic       cnt_dir;
  logic       cnt_rst_n, cnt_en, cnt_flip;
  logic [3:0] cnt_max, cnt_min;
  logic [1:0] grant, done, err;

  int total = 0;
  int bad   = 0;

  ping_pong_sched #(.TURN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .max_a(max_a), .min_a(min_a), .turns_a(turns_a),
    .max_b(max_b), .min_b(min_b), .turns_b(turns_b),
    .flip_req(flip_req), .cnt_out(cnt_out), .cnt_dir(cnt_dir),
    .cnt_rst_n(cnt_rst_n), .cnt_en(cnt_en), .cnt_flip(cnt_flip),
    .cnt_max(cnt_max), .cnt_min(cnt_min),
    .grant(grant), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Shared ping-pong counter: bounces between min and max, flip reverses before stepping.
  logic eff_dir;
  assign eff_dir = cnt_flip ? ~cnt_dir : cnt_dir;
  always @(posedge clk) begin
    if (!cnt_rst_n) begin
      cnt_out <= cnt_min;
      cnt_dir <= 1'b1;
    end else if (cnt_en) begin
      if (eff_dir) begin
        if (cnt_out >= cnt_max) begin cnt_dir <= 1'b0; cnt_out <= cnt_out - 4'd1; end
        else begin cnt_dir <= 1'b1; cnt_out <= cnt_out + 4'd1; end
      end else begin
        if (cnt_out <= cnt_min) begin cnt_dir <= 1'b1; cnt_out <= cnt_out + 4'd1; end
        else begin cnt_dir <= 1'b0; cnt_out <= cnt_out - 4'd1; end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00; flip_req = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Waits until a done pulse appears; returns cycles waited and counted enable cycles.
  task automatic wait_done(input int limit, output int n, output int en_cycles);
    n = 0; en_cycles = 0;
    while (done == 2'b00 && n < limit) begin
      en_cycles += int'(cnt_en);
      tick();
      n++;
    end
  endtask

  int seq1 [7] = '{2, 3, 4, 5, 4, 3, 2};
  int n, en_c;
  int m_ptr, chosen, lo[2], hi[2], tt[2], run_cyc, fin;
  logic [1:0] r, oh;
  logic ok[2];

  initial begin
    max_a = 0; min_a = 0; turns_a = 0; max_b = 0; min_b = 0; turns_b = 0;
    rst_n = 1'b0; req = 2'b00; flip_req = 2'b00;
    tick(); tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bounds", 32'({cnt_max, cnt_min}), 32'd0);
    check("rst_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_cnt_en", 32'(cnt_en), 32'd0);

    // Single grant 2..5, two turns
    min_a = 4'd2; max_a = 4'd5; turns_a = 4'd2; req = 2'b01;
    tick();
    check("sg_grant", 32'(grant), 32'h1);
    check("sg_load_rst", 32'(cnt_rst_n), 32'd0);
    check("sg_bounds", 32'({cnt_max, cnt_min}), 32'h52);
    tick();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) max_a = 4'd15;
      check("sg_cnt_out", 32'(cnt_out), 32'(seq1[i]));
      check("sg_cnt_en", 32'(cnt_en), (i < 6) ? 32'd1 : 32'd0);
      tick();
    end
    check("sg_done", 32'(done), 32'h1);
    check("sg_frozen", 32'(cnt_out), 32'd2);
    req = 2'b00; max_a = 4'd5;
    tick();
    check("sg_done_clr", 32'(done), 32'd0);
    check("sg_grant_clr", 32'(grant), 32'd0);

    // Contention out of reset
    do_reset();
    min_a = 4'd2; max_a = 4'd5; turns_a = 4'd1;
    min_b = 4'd1; max_b = 4'd3; turns_b = 4'd1;
    req = 2'b11;
    tick();
    check("ct_grant0", 32'(grant), 32'h1);
    wait_done(40, n, en_c);
    check("ct_done0", 32'(done), 32'h1);
    tick();
    check("ct_gap", 32'(grant), 32'd0);
    tick();
    check("ct_grant1", 32'(grant), 32'h2);
    wait_done(40, n, en_c);
    check("ct_done1", 32'(done), 32'h2);
    req = 2'b00;
    tick();

    // Invalid bounds on requester 1
    min_b = 4'd7; max_b = 4'd7; req = 2'b10;
    tick();
    check("inv_err", 32'(err), 32'h2);
    check("inv_grant", 32'(grant), 32'd0);
    check("inv_no_load", 32'(cnt_rst_n), 32'd1);
    req = 2'b00;
    tick();
    check("inv_err_clr", 32'(err), 32'd0);
    min_b = 4'd1; max_b = 4'd3; req = 2'b11;
    tick();
    check("inv_ptr0", 32'(grant), 32'h1);
    wait_done(40, n, en_c);
    req = 2'b00;
    tick();

    // Zero turn target
    turns_a = 4'd0; req = 2'b01;
    tick();
    check("zt_grant", 32'(grant), 32'h1);
    check("zt_en_load", 32'(cnt_en), 32'd0);
    tick();
    check("zt_done", 32'(done), 32'h1);
    check("zt_en_done", 32'(cnt_en), 32'd0);
    req = 2'b00;
    tick();
    check("zt_grant_clr", 32'(grant), 32'd0);

    // Flip routing
    min_a = 4'd0; max_a = 4'd9; turns_a = 4'd3; req = 2'b01;
    tick(); tick();
    n = 0;
    while (cnt_out != 4'd4 && n < 20) begin tick(); n++; end
    check("fl_reach4", 32'(cnt_out), 32'd4);
    flip_req = 2'b10; #1;
    check("fl_nonowner", 32'(cnt_flip), 32'd0);
    flip_req = 2'b01; #1;
    check("fl_owner", 32'(cnt_flip), 32'd1);
    tick();
    flip_req = 2'b00;
    check("fl_reversed", 32'(cnt_out), 32'd3);
    wait_done(60, n, en_c);
    check("fl_done", 32'(done), 32'h1);
    check("fl_final", 32'(cnt_out), 32'd0);
    req = 2'b00;
    tick();

    // Abort by owner 1
    min_b = 4'd1; max_b = 4'd8; turns_b = 4'd3; req = 2'b10;
    tick(); tick(); tick(); tick();
    req = 2'b00; #1;
    check("ab_en", 32'(cnt_en), 32'd0);
    tick();
    check("ab_grant", 32'(grant), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    tick();
    check("ab_no_done", 32'(done), 32'd0);

    // Reset mid-run
    req = 2'b10;
    tick(); tick(); tick();
    rst_n = 1'b0; #1;
    check("rr_cnt_rst_comb", 32'(cnt_rst_n), 32'd0);
    tick();
    check("rr_grant", 32'(grant), 32'd0);
    check("rr_cnt_rst", 32'(cnt_rst_n), 32'd0);
    rst_n = 1'b1; req = 2'b00;
    tick();

    // Randomized transactions against a round-robin / arithmetic model
    m_ptr = 0;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 2; k++) begin
        ok[k] = ($urandom_range(0, 3) != 0);
        if (ok[k]) begin
          lo[k] = $urandom_range(0, 14);
          hi[k] = $urandom_range(lo[k] + 1, 15);
        end else begin
          lo[k] = $urandom_range(0, 15);
          hi[k] = $urandom_range(0, lo[k]);
        end
        tt[k] = $urandom_range(0, 3);
      end
      min_a = 4'(lo[0]); max_a = 4'(hi[0]); turns_a = 4'(tt[0]);
      min_b = 4'(lo[1]); max_b = 4'(hi[1]); turns_b = 4'(tt[1]);
      r = 2'($urandom_range(1, 3));
      chosen = r[m_ptr] ? m_ptr : 1 - m_ptr;
      oh = (chosen == 1) ? 2'b10 : 2'b01;
      req = r;
      tick();
      if (!ok[chosen]) begin
        check("rnd_err", 32'(err), 32'(oh));
        check("rnd_err_grant", 32'(grant), 32'd0);
        req = 2'b00;
        tick();
        check("rnd_err_clr", 32'(err), 32'd0);
      end else begin
        check("rnd_grant", 32'(grant), 32'(oh));
        run_cyc = (tt[chosen] > 0) ? 1 + tt[chosen] * (hi[chosen] - lo[chosen]) : 0;
        fin = (tt[chosen] % 2 == 1) ? hi[chosen] : lo[chosen];
        wait_done(80, n, en_c);
        check("rnd_latency", 32'(n), 32'(1 + run_cyc));
        check("rnd_done", 32'(done), 32'(oh));
        check("rnd_final", 32'(cnt_out), 32'(fin));
        check("rnd_en_cycles", 32'(en_c), 32'(tt[chosen] * (hi[chosen] - lo[chosen])));
        req = 2'b00;
        tick();
        check("rnd_grant_clr", 32'(grant), 32'd0);
      end
      m_ptr = 1 - chosen;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
